// File: rtl/debug_access_initiator.sv
// debug_access_initiator
// Host-side initiator for the debug port. Commands arrive on a valid/ready
// channel and are access-checked against the registered unlock/lockout state.
// Permitted commands run one at a time on the debug bus. Each command ends with
// data and status returned on a valid/ready response channel.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only while idle)
//   cmd_write, cmd_addr, cmd_wdata command fields
//   rsp_valid/rsp_ready            response handshake, response held until taken
//   rsp_rdata, rsp_status          read data (0 unless OK read), status code
//   unlock_valid, unlock_key       one-cycle key presentation
//   unlocked, lockout              privileged window open / sticky lockout
//   dbg_addr, dbg_enable, dbg_wdata debug bus request side (zeroed when idle)
//   dbg_rdata, dbg_ready           debug bus responder side
module debug_access_initiator #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] UNLOCK_KEY     = 32'hA5C30F1E,
    parameter int          MAX_ATTEMPTS   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    input  logic        unlock_valid,
    input  logic [31:0] unlock_key,
    output logic        unlocked,
    output logic        lockout,
    output logic [7:0]  dbg_addr,
    output logic        dbg_enable,
    output logic [31:0] dbg_wdata,
    input  logic [31:0] dbg_rdata,
    input  logic        dbg_ready
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DENIED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_LOCKED  = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_n;
    logic [TW-1:0]  tcount, tcount_n;
    logic           is_write, is_write_n;
    logic [FW-1:0]  fail_cnt;

    logic           cmd_ready_n;
    logic           rsp_valid_n;
    logic [31:0]    rsp_rdata_n;
    logic [1:0]     rsp_status_n;
    logic           dbg_enable_n;
    logic [7:0]     dbg_addr_n;
    logic [31:0]    dbg_wdata_n;

    // State register and every FSM-driven output are registered here; the
    // combinational block below computes their next values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tcount     <= '0;
            is_write   <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
            dbg_enable <= 1'b0;
            dbg_addr   <= '0;
            dbg_wdata  <= '0;
        end else begin
            state      <= state_n;
            tcount     <= tcount_n;
            is_write   <= is_write_n;
            cmd_ready  <= cmd_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_rdata  <= rsp_rdata_n;
            rsp_status <= rsp_status_n;
            dbg_enable <= dbg_enable_n;
            dbg_addr   <= dbg_addr_n;
            dbg_wdata  <= dbg_wdata_n;
        end
    end

    // Next-state and next-output logic. tcount doubles as the first-WAIT-cycle
    // marker: it is zero only in the first WAIT cycle, because it increments
    // on every WAIT cycle that does not complete, so a stale dbg_ready left over
    // from earlier bus activity is ignored exactly then.
    always_comb begin
        state_n      = state;
        tcount_n     = tcount;
        is_write_n   = is_write;
        cmd_ready_n  = cmd_ready;
        rsp_valid_n  = rsp_valid;
        rsp_rdata_n  = rsp_rdata;
        rsp_status_n = rsp_status;
        dbg_enable_n = dbg_enable;
        dbg_addr_n   = dbg_addr;
        dbg_wdata_n  = dbg_wdata;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_n = 1'b0;
                    if (lockout) begin
                        state_n      = RESP;
                        rsp_valid_n  = 1'b1;
                        rsp_status_n = ST_LOCKED;
                        rsp_rdata_n  = '0;
                    end else if (cmd_addr[7:4] == 4'hF && !unlocked) begin
                        state_n      = RESP;
                        rsp_valid_n  = 1'b1;
                        rsp_status_n = ST_DENIED;
                        rsp_rdata_n  = '0;
                    end else begin
                        state_n      = WAIT;
                        tcount_n     = '0;
                        is_write_n   = cmd_write;
                        dbg_enable_n = 1'b1;
                        dbg_addr_n   = cmd_addr;
                        dbg_wdata_n  = cmd_write ? cmd_wdata : 32'd0;
                    end
                end
            end
            WAIT: begin
                if (tcount != '0 && dbg_ready) begin
                    state_n      = RESP;
                    dbg_enable_n = 1'b0;
                    dbg_addr_n   = '0;
                    dbg_wdata_n  = '0;
                    rsp_valid_n  = 1'b1;
                    rsp_status_n = ST_OK;
                    rsp_rdata_n  = is_write ? 32'd0 : dbg_rdata;
                end else if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n      = RESP;
                    dbg_enable_n = 1'b0;
                    dbg_addr_n   = '0;
                    dbg_wdata_n  = '0;
                    rsp_valid_n  = 1'b1;
                    rsp_status_n = ST_TIMEOUT;
                    rsp_rdata_n  = '0;
                end else begin
                    tcount_n = tcount + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n      = IDLE;
                    rsp_valid_n  = 1'b0;
                    rsp_rdata_n  = '0;
                    rsp_status_n = ST_OK;
                    cmd_ready_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Key handling runs independently of the FSM. A command accepted in the
    // same cycle as a key strobe sees the old unlocked/lockout values because
    // both are registers updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unlocked <= 1'b0;
            lockout  <= 1'b0;
            fail_cnt <= '0;
        end else if (unlock_valid && !lockout) begin
            if (unlock_key == UNLOCK_KEY) begin
                unlocked <= 1'b1;
                fail_cnt <= '0;
            end else begin
                unlocked <= 1'b0;
                if (fail_cnt != FW'(MAX_ATTEMPTS))
                    fail_cnt <= fail_cnt + FW'(1);
                if (fail_cnt >= FW'(MAX_ATTEMPTS - 1))
                    lockout <= 1'b1;
            end
        end
    end

endmodule
